// File: rtl/dot_fp_acc.sv
// dot_fp_acc: streaming FP dot product; per-beat integer sums are accumulated exactly across beats
// Each element maps to an exact fixed-point integer: subnormal -> {0,m}, normal -> {1,m} << (e-1).
module vec_mul_fp #(
    parameter int exp_width = 5,
    parameter int man_width = 2,
    parameter int k         = 32,
    parameter     USE_DSP   = "auto",
    parameter int bit_width = 1 + exp_width + man_width,
    parameter int prd_width = 2 * ((1 << exp_width) + man_width)
) (
    input  logic [bit_width*k-1:0] a,
    input  logic [bit_width*k-1:0] b,
    output logic [prd_width*k-1:0] prd
);
    localparam int fx_width = prd_width / 2;
    function automatic logic [fx_width-1:0] fx(input logic [bit_width-2:0] x);
        logic [exp_width-1:0] e;
        e = x[bit_width-2:man_width];
        return fx_width'({|e, x[man_width-1:0]}) << (e - exp_width'(e != '0));
    endfunction
    for (genvar i = 0; i < k; i++) begin : g_el
        logic [bit_width-1:0] xa, xb;
        logic [prd_width-1:0] mag;
        assign xa = a[i*bit_width +: bit_width];
        assign xb = b[i*bit_width +: bit_width];
        if (USE_DSP == "no") begin : g_lut
            (* use_dsp = "no" *) logic [prd_width-1:0] m;
            assign m   = prd_width'(fx(xa[bit_width-2:0])) * prd_width'(fx(xb[bit_width-2:0]));
            assign mag = m;
        end else begin : g_dsp
            assign mag = prd_width'(fx(xa[bit_width-2:0])) * prd_width'(fx(xb[bit_width-2:0]));
        end
        assign prd[i*prd_width +: prd_width] = (xa[bit_width-1] ^ xb[bit_width-1]) ? -mag : mag;
    end
endmodule

// vec_sum_int: sign-extending adder reduction of k signed integers
module vec_sum_int #(
    parameter int w = 68,
    parameter int k = 32
) (
    input  logic [w*k-1:0]            in,
    output logic [w+$clog2(k)-1:0]    sum
);
    localparam int sw = w + $clog2(k);
    // combinational reduction; each term sign-extended to the full sum width
    always_comb begin
        sum = '0;
        for (int j = 0; j < k; j++) sum = sum + sw'($signed(in[j*w +: w]));
    end
endmodule

module dot_fp_acc #(
    parameter int exp_width = 5,
    parameter int man_width = 2,
    parameter int k         = 32,
    parameter int max_beats = 16,
    parameter int bit_width = 1 + exp_width + man_width,
    parameter int prd_width = 2 * ((1 << exp_width) + man_width),
    parameter int sum_width = prd_width + $clog2(k),
    parameter int acc_width = sum_width + $clog2(max_beats) + 1,
    parameter int cnt_width = $clog2(max_beats + 1) + 1,
    parameter     USE_DSP   = "auto"
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic                   i_last,
    input  logic [bit_width*k-1:0] i_vec_a,
    input  logic [bit_width*k-1:0] i_vec_b,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [acc_width-1:0]   o_dp,
    output logic [cnt_width-1:0]   o_beats,
    output logic                   o_ovf
);
    logic                   en, accept;
    logic [bit_width*k-1:0] a0, b0;
    logic                   last0, v0;
    logic [prd_width*k-1:0] prd;
    logic [sum_width-1:0]   sum_c, sum1;
    logic                   last1, v1;
    logic [acc_width-1:0]   acc, acc_next;
    logic [cnt_width-1:0]   cnt, cnt_cur, cnt_next;
    logic                   first;

    assign en      = !(o_valid && !i_ready);
    assign o_ready = en;
    assign accept  = i_valid && en;

    vec_mul_fp #(
        .exp_width(exp_width), .man_width(man_width), .k(k), .USE_DSP(USE_DSP)
    ) u_mul (
        .a(a0), .b(b0), .prd(prd)
    );

    vec_sum_int #(.w(prd_width), .k(k)) u_sum (.in(prd), .sum(sum_c));

    // stage 0: capture accepted operands; the bubble clears only while advancing
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            a0    <= '0;
            b0    <= '0;
            last0 <= 1'b0;
            v0    <= 1'b0;
        end else if (accept) begin
            a0    <= i_vec_a;
            b0    <= i_vec_b;
            last0 <= i_last;
            v0    <= 1'b1;
        end else if (en) begin
            v0    <= 1'b0;
        end
    end

    // stage 1: register the per-beat reduced sum
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sum1  <= '0;
            last1 <= 1'b0;
            v1    <= 1'b0;
        end else if (en) begin
            sum1  <= sum_c;
            last1 <= last0;
            v1    <= v0;
        end
    end

    // a beat following a last beat (or reset) restarts both accumulator and counter
    always_comb begin
        cnt_cur  = first ? '0 : cnt;
        cnt_next = &cnt_cur ? cnt_cur : cnt_cur + cnt_width'(1);
        acc_next = (first ? '0 : acc) + acc_width'($signed(sum1));
    end

    // stage 2: accumulate, and publish the result on the last beat
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            acc     <= '0;
            cnt     <= '0;
            first   <= 1'b1;
            o_valid <= 1'b0;
            o_dp    <= '0;
            o_beats <= '0;
            o_ovf   <= 1'b0;
        end else begin
            if (en && v1 && last1) begin
                o_dp    <= acc_next;
                o_beats <= cnt_next;
                o_ovf   <= cnt_next > cnt_width'(max_beats);
                o_valid <= 1'b1;
                first   <= 1'b1;
            end else begin
                if (en && v1) begin
                    acc   <= acc_next;
                    cnt   <= cnt_next;
                    first <= 1'b0;
                end
                if (i_ready) o_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_dot_fp_acc.sv
// tb_dot_fp_acc: randomized and directed checks of dot_fp_acc against a behavioural model
module tb_dot_fp_acc;
    localparam int EW = 5, MW = 2, K = 32, MB = 16;
    localparam int PW = 2 * ((1 << EW) + MW);
    localparam int SW = PW + $clog2(K);
    localparam int AW = SW + $clog2(MB) + 1;
    localparam int CW = $clog2(MB + 1) + 1;

    logic            i_clk = 1'b0, i_rst_n, i_valid, i_last, i_ready;
    logic            o_ready, o_valid, o_ovf;
    logic [8*K-1:0]  i_vec_a, i_vec_b;
    logic [AW-1:0]   o_dp;
    logic [CW-1:0]   o_beats;

    typedef struct { logic [AW-1:0] dp; logic [CW-1:0] beats; logic ovf; } res_t;
    res_t q[$];
    res_t got[$];
    int tests = 0, fails = 0;
    logic signed [127:0] m_acc = 0;
    int m_n = 0;
    logic rand_ready = 1'b0;
    logic [8*K-1:0] one, neg, zero;
    logic [AW-1:0] e_val;

    dot_fp_acc dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_last(i_last), .i_vec_a(i_vec_a), .i_vec_b(i_vec_b), .o_valid(o_valid),
        .i_ready(i_ready), .o_dp(o_dp), .o_beats(o_beats), .o_ovf(o_ovf)
    );

    always #5 i_clk = ~i_clk;

    // E5M2 element as an exact integer: value scaled so that 1.0 maps to 2^16
    function automatic logic signed [127:0] val(input logic [7:0] x);
        logic signed [127:0] m;
        m = (x[6:2] == 5'd0) ? 128'(x[1:0]) : (128'(x[1:0]) + 128'd4) << (x[6:2] - 5'd1);
        return x[7] ? -m : m;
    endfunction

    function automatic logic signed [127:0] dot(input logic [8*K-1:0] a, input logic [8*K-1:0] b);
        logic signed [127:0] s = 0;
        for (int i = 0; i < K; i++) s += val(a[i*8 +: 8]) * val(b[i*8 +: 8]);
        return s;
    endfunction

    function automatic logic [7:0] rnd_el();
        logic [7:0] x;
        case ($urandom_range(0, 7))
            0: x = 8'h00;
            1: x = 8'h80;
            2: x = 8'h7B;
            3: x = 8'hFB;
            default: begin
                x = 8'($urandom);
                if (x[6:2] == 5'h1F) x[6] = 1'b0;
            end
        endcase
        return x;
    endfunction

    task automatic chk(input string name, input logic [127:0] g, input logic [127:0] e);
        tests++;
        if (g !== e) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, g, e);
        end
    endtask

    task automatic model_accept(input logic [8*K-1:0] a, input logic [8*K-1:0] b, input logic last);
        m_acc += dot(a, b);
        m_n++;
        if (last) begin
            q.push_back('{AW'(m_acc), CW'(m_n > 63 ? 63 : m_n), m_n > MB});
            m_acc = 0;
            m_n = 0;
        end
    endtask

    task automatic send(input logic [8*K-1:0] a, input logic [8*K-1:0] b, input logic last, input int idle);
        repeat (idle) begin
            @(negedge i_clk);
            i_valid = 1'b0;
            i_last  = 1'($urandom);
            i_vec_a = {K{rnd_el()}};
        end
        @(negedge i_clk);
        i_valid = 1'b1;
        i_vec_a = a;
        i_vec_b = b;
        i_last  = last;
        for (int t = 0; ; t++) begin
            #1;
            if (o_ready) break;
            if (t > 500) begin
                tests++;
                fails++;
                $display("FAIL send_timeout: o_ready stuck at %0b, required 1", o_ready);
                return;
            end
            @(negedge i_clk);
        end
        model_accept(a, b, last);
    endtask

    task automatic stop();
        @(negedge i_clk);
        i_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        for (t = 0; q.size() != 0 && t < 3000; t++) @(negedge i_clk);
        if (q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", q.size());
        end
        repeat (4) @(negedge i_clk);
    endtask

    task automatic rnd_vec(output logic [8*K-1:0] v);
        for (int i = 0; i < K; i++) v[i*8 +: 8] = rnd_el();
    endtask

    // random downstream back-pressure while enabled
    always @(negedge i_clk) if (rand_ready) i_ready = 1'($urandom_range(0, 1));

    // compare process: checked just before each rising edge, once the handshake inputs are settled
    always @(negedge i_clk) begin
        #2;
        if (i_rst_n && o_valid) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_result: got o_dp %0h with no result pending", o_dp);
            end else begin
                chk("o_dp", o_dp, q[0].dp);
                chk("o_beats", o_beats, q[0].beats);
                chk("o_ovf", o_ovf, q[0].ovf);
                if (i_ready) begin
                    got.push_back('{o_dp, o_beats, o_ovf});
                    void'(q.pop_front());
                end
            end
        end
    end

    initial begin
        one  = {K{8'h3C}};
        neg  = {K{8'hBC}};
        zero = '0;
        i_rst_n = 1'b0;
        i_valid = 1'b0;
        i_last  = 1'b0;
        i_ready = 1'b1;
        i_vec_a = '0;
        i_vec_b = '0;

        chk("model_val_1p0", val(8'h3C), 128'd65536);
        chk("model_val_maxnorm", val(8'h7B), 128'd7 << 29);
        chk("model_val_negzero", val(8'h80), 128'd0);
        chk("model_dot_1x1", dot(one, one), 128'd1 << 37);

        repeat (3) @(negedge i_clk);
        #2;
        chk("rst_o_valid", o_valid, 0);
        chk("rst_o_ready", o_ready, 1);
        chk("rst_o_dp", o_dp, 0);
        chk("rst_o_beats", o_beats, 0);
        chk("rst_o_ovf", o_ovf, 0);
        i_rst_n = 1'b1;

        // single beat, latency of two edges after acceptance
        send(one, one, 1'b1, 1);
        @(negedge i_clk);
        i_valid = 1'b0;
        #2 chk("lat_after_e", o_valid, 0);
        @(negedge i_clk);
        #2 chk("lat_after_e1", o_valid, 0);
        @(negedge i_clk);
        #2 chk("lat_after_e2", o_valid, 1);
        drain();
        chk("single_dp", got[got.size()-1].dp, AW'(1) << 37);
        chk("single_beats", got[got.size()-1].beats, 1);

        // 4-beat product followed without a gap by a 2-beat negative product
        got.delete();
        for (int i = 0; i < 4; i++) send(one, one, i == 3, 0);
        for (int i = 0; i < 2; i++) send(one, neg, i == 1, 0);
        stop();
        drain();
        chk("b2b_count", got.size(), 2);
        chk("b2b_dp4", got[0].dp, AW'(1) << 39);
        chk("b2b_beats4", got[0].beats, 4);
        e_val = -(AW'(1) << 38);
        chk("b2b_dpneg", got[1].dp, e_val);
        chk("b2b_beats2", got[1].beats, 2);

        // stall: two single-beat products with i_ready low
        got.delete();
        i_ready = 1'b0;
        send(one, one, 1'b1, 0);
        send(one, one, 1'b1, 0);
        stop();
        repeat (4) @(negedge i_clk);
        #1;
        chk("stall_o_ready", o_ready, 0);
        chk("stall_o_valid", o_valid, 1);
        chk("stall_o_dp", o_dp, AW'(1) << 37);
        @(negedge i_clk);
        i_ready = 1'b1;
        drain();
        chk("stall_count", got.size(), 2);

        // 17 beats overflow the beat budget, the next product is clean
        got.delete();
        for (int i = 0; i < 17; i++) send(one, one, i == 16, 0);
        send(one, one, 1'b1, 0);
        stop();
        drain();
        chk("ovf_beats", got[0].beats, 17);
        chk("ovf_flag", got[0].ovf, 1);
        chk("ovf_dp", got[0].dp, AW'(17) << 37);
        chk("ovf_next_flag", got[1].ovf, 0);
        chk("ovf_next_beats", got[1].beats, 1);

        // reset in the middle of a product discards the partial sum
        got.delete();
        for (int i = 0; i < 3; i++) send(one, one, 1'b0, 0);
        stop();
        i_rst_n = 1'b0;
        #1;
        chk("mid_rst_o_dp", o_dp, 0);
        chk("mid_rst_o_beats", o_beats, 0);
        m_acc = 0;
        m_n = 0;
        q.delete();
        @(negedge i_clk);
        i_rst_n = 1'b1;
        send(zero, zero, 1'b1, 0);
        stop();
        drain();
        chk("post_rst_dp", got[0].dp, 0);
        chk("post_rst_beats", got[0].beats, 1);

        // randomized products with input gaps and output back-pressure
        rand_ready = 1'b1;
        for (int p = 0; p < 40; p++) begin
            int nb;
            nb = $urandom_range(1, MB);
            for (int b = 0; b < nb; b++) begin
                logic [8*K-1:0] va, vb;
                rnd_vec(va);
                rnd_vec(vb);
                send(va, vb, b == nb - 1, $urandom_range(0, 2));
            end
        end
        stop();
        drain();
        rand_ready = 1'b0;
        i_ready = 1'b1;
        repeat (4) @(negedge i_clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
